// File: rtl/cnn_result_writer.sv
// Drains the accelerator result stream, packs pairs of results into bus words
// and writes them to consecutive 8-byte addresses, then pulses doneOut.
module cnn_result_writer #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                        clkIn,
    input  logic                        rstIn,
    input  logic                        startIn,
    input  logic [BUS_ADDR_WIDTH-1:0]   baseAddrIn,
    input  logic [CNT_WIDTH-1:0]        numResultsIn,
    input  logic [DATA_WIDTH-1:0]       dataIn,
    input  logic                        validIn,
    output logic                        readyOut,
    output logic [BUS_ADDR_WIDTH-1:0]   busAddrOut,
    output logic [BUS_DATA_WIDTH/8-1:0] busWrEnOut,
    output logic [BUS_DATA_WIDTH-1:0]   busWrDataOut,
    output logic                        busValidOut,
    input  logic                        busReadyIn,
    output logic                        busyOut,
    output logic                        doneOut
);

    localparam int BE_WIDTH = BUS_DATA_WIDTH / 8;
    localparam int LANE_BE  = DATA_WIDTH / 8;
    localparam logic [BUS_ADDR_WIDTH-1:0] ADDR_STEP = BUS_ADDR_WIDTH'(BE_WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PACK  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                state;
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [CNT_WIDTH-1:0]      remaining;
    logic                      lane;
    logic [BUS_DATA_WIDTH-1:0] word;
    logic [BE_WIDTH-1:0]       byte_en;
    logic                      done;

    // Bus outputs come straight from registers so they stay frozen while the bus stalls.
    assign readyOut     = (state == PACK);
    assign busValidOut  = (state == WRITE);
    assign busyOut      = (state != IDLE);
    assign doneOut      = done;
    assign busAddrOut   = addr;
    assign busWrDataOut = word;
    assign busWrEnOut   = byte_en;

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            lane      <= 1'b0;
            word      <= '0;
            byte_en   <= '0;
            done      <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (startIn) begin
                        addr      <= baseAddrIn;
                        remaining <= numResultsIn;
                        lane      <= 1'b0;
                        word      <= '0;
                        byte_en   <= '0;
                        state     <= (numResultsIn == '0) ? DONE : PACK;
                    end
                end
                PACK: begin
                    if (validIn) begin
                        word[int'(lane)*DATA_WIDTH +: DATA_WIDTH] <= dataIn;
                        byte_en[int'(lane)*LANE_BE +: LANE_BE]    <= '1;
                        remaining <= remaining - CNT_WIDTH'(1);
                        lane      <= ~lane;
                        // A word goes out when full or when it holds the final result.
                        if (lane || (remaining == CNT_WIDTH'(1))) begin
                            state <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (busReadyIn) begin
                        addr    <= addr + ADDR_STEP;
                        word    <= '0;
                        byte_en <= '0;
                        lane    <= 1'b0;
                        state   <= (remaining == '0) ? DONE : PACK;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_result_writer.sv
// Randomized bench for cnn_result_writer: drives stream and bus, captures every
// accepted write and compares it with a word-packing reference model.
module tb_cnn_result_writer;

    logic        clkIn = 1'b0;
    logic        rstIn;
    logic        startIn;
    logic [31:0] baseAddrIn;
    logic [15:0] numResultsIn;
    logic [31:0] dataIn;
    logic        validIn;
    logic        readyOut;
    logic [31:0] busAddrOut;
    logic [7:0]  busWrEnOut;
    logic [63:0] busWrDataOut;
    logic        busValidOut;
    logic        busReadyIn;
    logic        busyOut;
    logic        doneOut;

    cnn_result_writer #(
        .BUS_ADDR_WIDTH(32), .BUS_DATA_WIDTH(64), .DATA_WIDTH(32), .CNT_WIDTH(16)
    ) dut (
        .clkIn(clkIn), .rstIn(rstIn), .startIn(startIn), .baseAddrIn(baseAddrIn),
        .numResultsIn(numResultsIn), .dataIn(dataIn), .validIn(validIn),
        .readyOut(readyOut), .busAddrOut(busAddrOut), .busWrEnOut(busWrEnOut),
        .busWrDataOut(busWrDataOut), .busValidOut(busValidOut), .busReadyIn(busReadyIn),
        .busyOut(busyOut), .doneOut(doneOut)
    );

    always #5 clkIn = ~clkIn;

    int n_checks = 0;
    int n_fail   = 0;

    // Transfer record filled by run_xfer; writes packed as {addr, data, enables}.
    logic [31:0]  vals_q[$];
    logic [103:0] got_q[$];
    logic [103:0] exp_q[$];
    int           wcyc_q[$];
    int           done_cnt, done_cyc, sent_cnt, stall_viol, overlap, timeout;

    // Reference: results taken in pairs, first result in the low half, a lone
    // trailing result padded with zero and only its low four bytes enabled.
    function automatic void build_expected(input logic [31:0] base, input int n);
        logic [31:0] lo, hi, a;
        logic [7:0]  be;
        exp_q.delete();
        for (int k = 0; 2 * k < n; k++) begin
            lo = vals_q[2*k];
            hi = (2 * k + 1 < n) ? vals_q[2*k+1] : 32'h0;
            be = (2 * k + 1 < n) ? 8'hFF : 8'h0F;
            a  = base + 32'(8 * k);
            exp_q.push_back({a, hi, lo, be});
        end
    endfunction

    task automatic run_xfer(input logic [31:0] base, input int n, input int vprob,
                            input int rprob, input int stall_first, input bit noise);
        int          idx = 0, cyc = 0, stalls = 0, after = 0;
        bit          seen_done = 0, vld;
        logic        pend = 1'b0;
        logic [103:0] held = '0;
        vals_q.delete(); got_q.delete(); wcyc_q.delete();
        done_cnt = 0; done_cyc = -1; stall_viol = 0; overlap = 0; timeout = 0;
        for (int i = 0; i < n; i++) vals_q.push_back($urandom);
        startIn = 1'b1; baseAddrIn = base; numResultsIn = 16'(n);
        @(posedge clkIn); #1;
        startIn = 1'b0; baseAddrIn = $urandom; numResultsIn = 16'($urandom);
        while (1) begin
            cyc++;
            if (pend && (!busValidOut || {busAddrOut, busWrDataOut, busWrEnOut} !== held))
                stall_viol++;
            if (readyOut && busValidOut) overlap++;
            if (doneOut) begin
                done_cnt++;
                if (!seen_done) done_cyc = cyc;
                seen_done = 1;
            end
            vld = (idx < n) && ($urandom_range(99) < vprob);
            validIn = vld;
            dataIn  = vld ? vals_q[idx] : $urandom;
            if (busValidOut && stalls < stall_first) begin
                busReadyIn = 1'b0;
                stalls++;
                if (readyOut) overlap++;
            end else begin
                busReadyIn = ($urandom_range(99) < rprob);
            end
            startIn = noise && (readyOut || busValidOut) && ($urandom_range(1) == 1);
            if (startIn) begin
                baseAddrIn = $urandom; numResultsIn = 16'($urandom);
            end
            if (readyOut && vld) idx++;
            if (busValidOut && busReadyIn) begin
                got_q.push_back({busAddrOut, busWrDataOut, busWrEnOut});
                wcyc_q.push_back(cyc);
            end
            pend = busValidOut && !busReadyIn;
            held = {busAddrOut, busWrDataOut, busWrEnOut};
            if (seen_done) after++;
            if (after > 3 || cyc >= 3000) break;
            @(posedge clkIn); #1;
        end
        if (!seen_done) timeout = 1;
        sent_cnt = idx;
        validIn = 1'b0; busReadyIn = 1'b0; startIn = 1'b0;
        @(posedge clkIn); #1;
    endtask

    task automatic test_reset;
        rstIn = 1'b1;
        startIn = 1'b1; validIn = 1'b1; busReadyIn = 1'b1;
        baseAddrIn = 32'h1000; numResultsIn = 16'd4; dataIn = 32'hDEADBEEF;
        repeat (3) @(posedge clkIn);
        #1;
        n_checks++;
        if ({readyOut, busValidOut, busyOut, doneOut} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 0000", {readyOut, busValidOut, busyOut, doneOut});
        end
        n_checks++;
        if ({busAddrOut, busWrDataOut, busWrEnOut} !== 104'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got %h required 0", {busAddrOut, busWrDataOut, busWrEnOut});
        end
        startIn = 1'b0; validIn = 1'b0; busReadyIn = 1'b0;
        rstIn = 1'b0;
        @(posedge clkIn); #1;
        n_checks++;
        if (busyOut !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b required 0", busyOut);
        end
    endtask

    task automatic test_basic_four;
        run_xfer(32'h1000, 4, 100, 100, 0, 0);
        build_expected(32'h1000, 4);
        n_checks++;
        if (got_q.size() != 2 || timeout != 0) begin
            n_fail++;
            $display("FAIL basic_count: got %0d writes timeout %0d required 2 writes timeout 0", got_q.size(), timeout);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: got %h required %h", k, got_q[k], exp_q[k]);
                end
            end
            n_checks++;
            if (wcyc_q[0] != 3 || wcyc_q[1] != 6) begin
                n_fail++;
                $display("FAIL basic_latency: got cycles %0d,%0d required 3,6", wcyc_q[0], wcyc_q[1]);
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 8) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses at %0d required 1 at 8", done_cnt, done_cyc);
        end
    endtask

    task automatic test_odd_three;
        run_xfer(32'h1000, 3, 100, 100, 0, 0);
        build_expected(32'h1000, 3);
        n_checks++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL odd_count: got %0d required 2", got_q.size());
        end else begin
            n_checks++;
            if (got_q[1] !== {32'h1008, 32'h0, vals_q[2], 8'h0F} || got_q[0] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL odd_tail: got %h required %h", got_q[1], {32'h1008, 32'h0, vals_q[2], 8'h0F});
            end
            n_checks++;
            if (wcyc_q[1] != 5) begin
                n_fail++;
                $display("FAIL odd_latency: got %0d required 5", wcyc_q[1]);
            end
        end
    endtask

    task automatic test_zero;
        run_xfer(32'h2000, 0, 100, 100, 0, 0);
        n_checks++;
        if (got_q.size() != 0 || overlap != 0 || sent_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_nowrite: got %0d writes %0d accepted required 0 0", got_q.size(), sent_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != 2) begin
            n_fail++;
            $display("FAIL zero_done: got %0d pulses at %0d required 1 at 2", done_cnt, done_cyc);
        end
    endtask

    task automatic test_bus_stall;
        run_xfer(32'h3000, 2, 100, 100, 5, 0);
        build_expected(32'h3000, 2);
        n_checks++;
        if (stall_viol != 0 || overlap != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d changes %0d ready-in-write required 0 0", stall_viol, overlap);
        end
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || wcyc_q[0] != 8) begin
            n_fail++;
            $display("FAIL stall_write: got %0d writes first %h required 1 write %h at cycle 8",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 104'h0, exp_q[0]);
        end
    endtask

    task automatic test_gaps_seven;
        run_xfer(32'h4000, 7, 40, 100, 0, 0);
        build_expected(32'h4000, 7);
        n_checks++;
        if (got_q.size() != 4 || timeout != 0) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d required 4", got_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL gaps_write%0d: got %h required %h", k, got_q[k], exp_q[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        startIn = 1'b1; baseAddrIn = 32'h5000; numResultsIn = 16'd4;
        @(posedge clkIn); #1;
        startIn = 1'b0; validIn = 1'b1; dataIn = 32'hA5A5_0001; busReadyIn = 1'b1;
        @(posedge clkIn); #1;
        validIn = 1'b0;
        rstIn = 1'b1;
        @(posedge clkIn); #1;
        rstIn = 1'b0;
        n_checks++;
        if ({readyOut, busValidOut, busyOut, busWrEnOut, busWrDataOut, busAddrOut} !== 107'h0) begin
            n_fail++;
            $display("FAIL midreset_clear: got ready %b valid %b busy %b be %h",
                     readyOut, busValidOut, busyOut, busWrEnOut);
        end
        overlap = 0;
        repeat (5) begin
            @(posedge clkIn); #1;
            if (busValidOut || doneOut) overlap++;
        end
        n_checks++;
        if (overlap != 0) begin
            n_fail++;
            $display("FAIL midreset_nowrite: got %0d active cycles required 0", overlap);
        end
        run_xfer(32'h6000, 2, 100, 100, 0, 0);
        build_expected(32'h6000, 2);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0] || done_cnt != 1) begin
            n_fail++;
            $display("FAIL midreset_restart: got %0d writes %0d dones required 1 write %h 1 done",
                     got_q.size(), done_cnt, exp_q[0]);
        end
    endtask

    task automatic test_addr_wrap;
        run_xfer(32'hFFFF_FFF8, 4, 100, 100, 0, 0);
        build_expected(32'hFFFF_FFF8, 4);
        n_checks++;
        if (got_q.size() != 2 || got_q[1][103:72] !== 32'h0 || got_q[1] !== exp_q[1]) begin
            n_fail++;
            $display("FAIL addr_wrap: got %0d writes, second %h required %h",
                     got_q.size(), (got_q.size() > 1) ? got_q[1] : 104'h0, exp_q[1]);
        end
    endtask

    task automatic test_random;
        logic [31:0] base;
        int          n;
        for (int t = 0; t < 8; t++) begin
            base = $urandom & 32'hFFFF_FFF8;
            n    = $urandom_range(9);
            run_xfer(base, n, 60, 60, 0, 1);
            build_expected(base, n);
            n_checks++;
            if (got_q.size() != exp_q.size() || done_cnt != 1 || sent_cnt != n ||
                timeout != 0 || stall_viol != 0 || overlap != 0) begin
                n_fail++;
                $display("FAIL rand%0d_shape: got %0d writes %0d dones %0d taken viol %0d required %0d writes 1 done %0d taken",
                         t, got_q.size(), done_cnt, sent_cnt, stall_viol, exp_q.size(), n);
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    n_checks++;
                    if (got_q[k] !== exp_q[k]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: got %h required %h", t, k, got_q[k], exp_q[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        rstIn = 1'b1; startIn = 1'b0; validIn = 1'b0; busReadyIn = 1'b0;
        baseAddrIn = '0; numResultsIn = '0; dataIn = '0;
        @(posedge clkIn); #1;
        test_reset();
        test_basic_four();
        test_odd_three();
        test_zero();
        test_bus_stall();
        test_gaps_seven();
        test_reset_mid();
        test_addr_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
